sram_arbiter: RTL and testbench

- Single-port scheduler for the external 256Kx16 SRAM, shared by three requesters: video fetch, CPU (T8080se), and an auxiliary DMA port (FDC sector buffer / tape loader).
- Fixed-priority, non-preemptive, 2-cycle accesses at clk24.
- Replaces the combinational video_slice address mux and write-strobe logic in front of sram_map.
- Owns every SRAM pin except CE_N, which stays tied low at top level.

---
 rtl/vector_sram_pkg.sv | 35 +++
 rtl/sram_lane_mux.sv | 29 ++
 rtl/sram_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_sram_pkg.sv
// ----------------------------------------------------------------------------
// vector_sram_pkg
// Shared types and constants for the SRAM arbiter: FSM states, bus owners,
// default timing and byte-lane select values.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package vector_sram_pkg;

  // Access phases; PH1 may last two cycles when ACC_CYCLES is 3.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH1  = 2'd1,
    ST_PH2  = 2'd2
  } state_e;

  // Current owner of the SRAM bus.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_AUX  = 2'd3
  } owner_e;

  localparam int ACC_CYCLES_DEF = 2;
  localparam int AUX_STARVE_DEF = 8;

  // Byte-address bit 0 selects the lane: 0 = low byte, 1 = high byte.
  localparam logic LANE_LB = 1'b0;
  localparam logic LANE_UB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sram_lane_mux.sv
// ----------------------------------------------------------------------------
// sram_lane_mux
// Byte-to-word steering for 8-bit requesters on the 16-bit SRAM: write byte
// replication, lane strobe selection and read byte extraction.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module sram_lane_mux
  import vector_sram_pkg::*;
(
  input  logic        lane_i,
  input  logic [7:0]  wbyte_i,
  input  logic [15:0] rword_i,
  output logic [15:0] wword_o,
  output logic        ub_n_o,
  output logic        lb_n_o,
  output logic [7:0]  rbyte_o
);

  // Byte is driven on both halves; only the selected lane strobe enables it.
  assign wword_o = {wbyte_i, wbyte_i};
  assign ub_n_o  = (lane_i != LANE_UB);
  assign lb_n_o  = (lane_i != LANE_LB);
  assign rbyte_o = (lane_i == LANE_UB) ? rword_i[15:8] : rword_i[7:0];

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ----------------------------------------------------------------------------
// sram_arbiter
// Fixed-priority, non-preemptive scheduler for a 256Kx16 SRAM shared by video
// fetch, CPU and an auxiliary DMA port. Priority: video, starved aux, CPU,
// aux. Optional macro RAMDISK_EN maps CPU ramdisk accesses to the upper
// 128K words using rd_bank.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module sram_arbiter
  import vector_sram_pkg::*;
#(
  parameter int ACC_CYCLES = ACC_CYCLES_DEF,
  parameter int AUX_STARVE = AUX_STARVE_DEF
) (
  input  logic        clk24,
  input  logic        mreset,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [15:0] aux_addr,
  input  logic [7:0]  aux_wdata,
  output logic [7:0]  aux_rdata,
  output logic        aux_ack,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  input  logic [1:0]  rd_bank,
  input  logic        rd_sel
);

  localparam int SW = $clog2(AUX_STARVE + 1);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  owner_e        gnt;
  logic          ph_cnt_q, ph_cnt_d;
  logic [17:0]   addr_q, addr_d;
  logic          lane_q, lane_d;
  logic          we_q, we_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          vid_prev_q;
  logic          vid_pending_q, vid_pending_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          cpu_ack_q, aux_ack_q, vid_valid_q;
  logic [15:0]   vid_data_q;
  logic [7:0]    cpu_rdata_q, aux_rdata_q;

  logic [2:0]    cpu_bank;
  logic          vid_rise, vid_want, arb_point, port_ok, force_aux;
  logic          active, done;
  logic [15:0]   lane_wword;
  logic          lane_ub_n, lane_lb_n;
  logic [7:0]    lane_rbyte;

`ifdef RAMDISK_EN
  assign cpu_bank = rd_sel ? {1'b1, rd_bank} : 3'b000;
  logic unused_in;
  assign unused_in = vid_addr[0];
`else
  assign cpu_bank = 3'b000;
  logic unused_in;
  assign unused_in = ^{vid_addr[0], rd_bank, rd_sel};
`endif

  // Video is edge-triggered: one fetch per rising vid_req, remembered while busy.
  assign vid_rise  = vid_req & ~vid_prev_q;
  assign vid_want  = vid_pending_q | vid_rise;
  assign arb_point = (state_q == ST_IDLE) || (state_q == ST_PH2);
  // CPU/aux may chain only behind video; the ack cycle is dead for them so a
  // held request is never granted twice.
  assign port_ok   = (state_q == ST_IDLE) ? ~(cpu_ack_q | aux_ack_q)
                                          : (owner_q == OWN_VID);
  assign force_aux = aux_req && (starve_q == SW'(AUX_STARVE));
  assign active    = (state_q != ST_IDLE);
  assign done      = (state_q == ST_PH2);

  // Fixed-priority grant selection at arbitration points.
  always_comb begin
    gnt = OWN_NONE;
    if (arb_point) begin
      if (vid_want)       gnt = OWN_VID;
      else if (port_ok) begin
        if (force_aux)    gnt = OWN_AUX;
        else if (cpu_req) gnt = OWN_CPU;
        else if (aux_req) gnt = OWN_AUX;
      end
    end
  end

  // Next-state, grant capture and bookkeeping.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ph_cnt_d      = ph_cnt_q;
    addr_d        = addr_q;
    lane_d        = lane_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    vid_pending_d = (vid_pending_q | vid_rise) & (gnt != OWN_VID);
    starve_d      = starve_q;

    if (!aux_req || gnt == OWN_AUX) starve_d = '0;
    else if (gnt == OWN_CPU)        starve_d = starve_q + SW'(1);

    case (state_q)
      ST_IDLE, ST_PH2: begin
        ph_cnt_d = 1'b0;
        state_d  = (gnt == OWN_NONE) ? ST_IDLE : ST_PH1;
        owner_d  = gnt;
        case (gnt)
          OWN_VID: begin
            addr_d = {3'b000, vid_addr[15:1]};
            we_d   = 1'b0;
            lane_d = LANE_LB;
          end
          OWN_CPU: begin
            addr_d  = {cpu_bank, cpu_addr[15:1]};
            we_d    = cpu_we;
            lane_d  = cpu_addr[0];
            wdata_d = cpu_wdata;
          end
          OWN_AUX: begin
            addr_d  = {3'b000, aux_addr[15:1]};
            we_d    = aux_we;
            lane_d  = aux_addr[0];
            wdata_d = aux_wdata;
          end
          default: ;
        endcase
      end
      ST_PH1: begin
        if (ACC_CYCLES == 3 && !ph_cnt_q) ph_cnt_d = 1'b1;
        else                              state_d  = ST_PH2;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State and access registers; reset abandons any access in flight.
  always_ff @(posedge clk24) begin
    if (mreset) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_NONE;
      ph_cnt_q      <= 1'b0;
      addr_q        <= '0;
      lane_q        <= LANE_LB;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      vid_prev_q    <= 1'b0;
      vid_pending_q <= 1'b0;
      starve_q      <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ph_cnt_q      <= ph_cnt_d;
      addr_q        <= addr_d;
      lane_q        <= lane_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      vid_prev_q    <= vid_req;
      vid_pending_q <= vid_pending_d;
      starve_q      <= starve_d;
    end
  end

  // Completion strobes and read data captured at the end of PH2.
  always_ff @(posedge clk24) begin
    if (mreset) begin
      cpu_ack_q   <= 1'b0;
      aux_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      cpu_ack_q   <= done && (owner_q == OWN_CPU);
      aux_ack_q   <= done && (owner_q == OWN_AUX);
      vid_valid_q <= done && (owner_q == OWN_VID);
      if (done && owner_q == OWN_VID)            vid_data_q  <= sram_dq_i;
      if (done && owner_q == OWN_CPU && !we_q)   cpu_rdata_q <= lane_rbyte;
      if (done && owner_q == OWN_AUX && !we_q)   aux_rdata_q <= lane_rbyte;
    end
  end

  sram_lane_mux u_lane_mux (
    .lane_i  (lane_q),
    .wbyte_i (wdata_q),
    .rword_i (sram_dq_i),
    .wword_o (lane_wword),
    .ub_n_o  (lane_ub_n),
    .lb_n_o  (lane_lb_n),
    .rbyte_o (lane_rbyte)
  );

  assign sram_addr  = addr_q;
  assign sram_dq_o  = lane_wword;
  assign sram_dq_oe = active & we_q;
  assign sram_we_n  = ~((state_q == ST_PH1) & we_q);
  assign sram_oe_n  = ~(active & ~we_q);
  assign sram_ub_n  = active ? ((owner_q == OWN_VID) ? 1'b0 : lane_ub_n) : 1'b1;
  assign sram_lb_n  = active ? ((owner_q == OWN_VID) ? 1'b0 : lane_lb_n) : 1'b1;

  assign vid_data   = vid_data_q;
  assign vid_valid  = vid_valid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign aux_rdata  = aux_rdata_q;
  assign aux_ack    = aux_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_arbiter
// Directed self-checking bench for sram_arbiter with a behavioural SRAM.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sram_arbiter;

  logic        clk24 = 1'b0;
  logic        mreset;
  logic        vid_req, cpu_req, cpu_we, aux_req, aux_we, rd_sel;
  logic [15:0] vid_addr, cpu_addr, aux_addr;
  logic [7:0]  cpu_wdata, aux_wdata;
  logic [1:0]  rd_bank;
  logic [15:0] vid_data, sram_dq_o;
  logic        vid_valid, cpu_ack, aux_ack;
  logic [7:0]  cpu_rdata, aux_rdata;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_i = 16'h0000;
  logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  logic [15:0] mem [logic [17:0]];

  always #5 clk24 = ~clk24;

  sram_arbiter dut (
    .clk24(clk24), .mreset(mreset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_rdata(aux_rdata), .aux_ack(aux_ack),
    .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
    .rd_bank(rd_bank), .rd_sel(rd_sel)
  );

  // Unwritten words read back as a fixed address-derived pattern.
  function automatic logic [15:0] mem_rd(input logic [17:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // SRAM model: byte-lane writes while we_n is low, reads while oe_n is low.
  always @(posedge clk24) begin
    logic [15:0] w;
    if (!sram_we_n) begin
      w = mem_rd(sram_addr);
      if (!sram_ub_n) w[15:8] = sram_dq_o[15:8];
      if (!sram_lb_n) w[7:0]  = sram_dq_o[7:0];
      mem[sram_addr] = w;
    end
  end

  always @(negedge clk24) begin
    sram_dq_i = sram_oe_n ? 16'h0000 : mem_rd(sram_addr);
    if (!sram_we_n && !sram_oe_n) overlap++;
  end

  task automatic step();
    @(posedge clk24);
    #1;
  endtask

  task automatic test_reset();
    mreset = 1'b1;
    vid_req = 0; cpu_req = 0; aux_req = 0; cpu_we = 0; aux_we = 0;
    vid_addr = 0; cpu_addr = 0; aux_addr = 0; cpu_wdata = 0; aux_wdata = 0;
    rd_sel = 0; rd_bank = 0;
    step(); step();
    checks++;
    if ({sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 5'b11110) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 11110",
               {sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe});
    end
    checks++;
    if ({cpu_ack, aux_ack, vid_valid} !== 3'b000 || sram_addr !== 18'h0) begin
      errors++;
      $display("FAIL reset_ack_addr: got acks %b addr %h expected 000 / 00000",
               {cpu_ack, aux_ack, vid_valid}, sram_addr);
    end
    checks++;
    if (vid_data !== 16'h0 || cpu_rdata !== 8'h0 || aux_rdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h expected zeros", vid_data, cpu_rdata, aux_rdata);
    end
    mreset = 1'b0;
    step();
  endtask

  task automatic test_cpu_write_read();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h1235; cpu_wdata = 8'hA5;
    step();  // grant edge, now PH1
    checks++;
    if (sram_addr !== 18'h0091A || sram_ub_n !== 1'b0 || sram_lb_n !== 1'b1 ||
        sram_we_n !== 1'b0 || sram_dq_o !== 16'hA5A5 || sram_dq_oe !== 1'b1) begin
      errors++;
      $display("FAIL cpu_write_ph1: got addr %h ub %b lb %b we %b dq %h oe %b expected 0091a 0 1 0 a5a5 1",
               sram_addr, sram_ub_n, sram_lb_n, sram_we_n, sram_dq_o, sram_dq_oe);
    end
    step();  // PH2
    checks++;
    if (sram_we_n !== 1'b1 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL cpu_write_ph2: got we_n %b ack %b expected 1 0", sram_we_n, cpu_ack);
    end
    step();  // ack cycle
    checks++;
    if (cpu_ack !== 1'b1) begin
      errors++;
      $display("FAIL cpu_write_ack: got %b expected 1", cpu_ack);
    end
    cpu_req = 0;
    step();
    cpu_req = 1; cpu_we = 0; cpu_wdata = 8'h00;
    step();  // PH1 of read
    checks++;
    if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_ub_n !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_ph1: got oe_n %b we_n %b dq_oe %b ub_n %b expected 0 1 0 0",
               sram_oe_n, sram_we_n, sram_dq_oe, sram_ub_n);
    end
    step(); step();  // ack at cycle 3 after grant
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL cpu_read_ack: got ack %b rdata %h expected 1 a5", cpu_ack, cpu_rdata);
    end
    cpu_req = 0;
    step(); step();
  endtask

  task automatic test_video_during_cpu();
    int nvalid;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
    step();  // CPU PH1
    vid_req = 1; vid_addr = 16'h8000;
    step();  // CPU PH2, video pending
    step();  // CPU ack, video PH1
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hDA) begin
      errors++;
      $display("FAIL vid_cpu_first: got ack %b rdata %h expected 1 da", cpu_ack, cpu_rdata);
    end
    checks++;
    if (sram_addr !== 18'h04000 || sram_oe_n !== 1'b0 || sram_ub_n !== 1'b0 || sram_lb_n !== 1'b0) begin
      errors++;
      $display("FAIL vid_grant_ph1: got addr %h oe_n %b ub_n %b lb_n %b expected 04000 0 0 0",
               sram_addr, sram_oe_n, sram_ub_n, sram_lb_n);
    end
    cpu_req = 0;
    step(); step();  // video valid
    checks++;
    if (vid_valid !== 1'b1 || vid_data !== 16'h1A5A) begin
      errors++;
      $display("FAIL vid_valid_data: got valid %b data %h expected 1 1a5a", vid_valid, vid_data);
    end
    // vid_req still held: no further fetches
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (vid_valid) nvalid++;
    end
    checks++;
    if (nvalid !== 0) begin
      errors++;
      $display("FAIL vid_held_single: got %0d extra fetches expected 0", nvalid);
    end
    vid_req = 0;
    step(); step();
  endtask

  task automatic test_starvation();
    byte ev [$];
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
    aux_req = 1; aux_we = 0; aux_addr = 16'h0051;
    for (int i = 0; i < 120 && ev.size() < 18; i++) begin
      step();
      if (cpu_ack) ev.push_back("C");
      if (aux_ack) ev.push_back("A");
    end
    cpu_req = 0; aux_req = 0;
    checks++;
    if (ev.size() != 18) begin
      errors++;
      $display("FAIL starve_count: got %0d grants expected 18", ev.size());
    end else begin
      for (int i = 0; i < 18; i++) begin
        byte exp_g;
        exp_g = (i == 8 || i == 17) ? "A" : "C";
        checks++;
        if (ev[i] !== exp_g) begin
          errors++;
          $display("FAIL starve_order[%0d]: got %s expected %s", i, ev[i], exp_g);
        end
      end
    end
    checks++;
    if (aux_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL aux_rdata: got %h expected 5a", aux_rdata);
    end
    step(); step();
  endtask

  task automatic test_simultaneous();
    byte ev [$];
    overlap = 0;
    vid_req = 1; vid_addr = 16'h0200;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 8'h11;
    aux_req = 1; aux_we = 1; aux_addr = 16'h0020; aux_wdata = 8'h22;
    for (int i = 0; i < 30 && ev.size() < 3; i++) begin
      step();
      if (vid_valid) ev.push_back("V");
      if (cpu_ack) begin ev.push_back("C"); cpu_req = 0; end
      if (aux_ack) begin ev.push_back("A"); aux_req = 0; end
    end
    cpu_req = 0; aux_req = 0; vid_req = 0;
    checks++;
    if (ev.size() != 3 || ev[0] !== "V" || ev[1] !== "C" || ev[2] !== "A") begin
      errors++;
      $display("FAIL simul_order: got %0d events %s%s%s expected VCA", ev.size(),
               (ev.size() > 0) ? ev[0] : "-", (ev.size() > 1) ? ev[1] : "-",
               (ev.size() > 2) ? ev[2] : "-");
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL simul_overlap: got %0d we_n/oe_n overlaps expected 0", overlap);
    end
    step(); step();
  endtask

  task automatic test_reset_mid_access();
    int nack;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0300; cpu_wdata = 8'h3C;
    step();  // PH1 of write
    checks++;
    if (sram_we_n !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre: got we_n %b expected 0", sram_we_n);
    end
    mreset = 1;
    step();
    checks++;
    if ({sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 5'b11110 || sram_addr !== 18'h0) begin
      errors++;
      $display("FAIL midrst_strobes: got %b addr %h expected 11110 00000",
               {sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe}, sram_addr);
    end
    mreset = 0; cpu_req = 0;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cpu_ack || !sram_oe_n || !sram_we_n) nack++;
    end
    checks++;
    if (nack !== 0) begin
      errors++;
      $display("FAIL midrst_noack: got %0d active cycles expected 0", nack);
    end
  endtask

  task automatic test_ramdisk();
    logic [17:0] exp_a;
`ifdef RAMDISK_EN
    exp_a = 18'h30001;
`else
    exp_a = 18'h00001;
`endif
    rd_sel = 1; rd_bank = 2'b10;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0002;
    step();
    checks++;
    if (sram_addr !== exp_a) begin
      errors++;
      $display("FAIL ramdisk_cpu: got %h expected %h", sram_addr, exp_a);
    end
    step(); step();
    cpu_req = 0;
    step();
    aux_req = 1; aux_we = 0; aux_addr = 16'h0004;
    step();
    checks++;
    if (sram_addr !== 18'h00002) begin
      errors++;
      $display("FAIL ramdisk_aux: got %h expected 00002", sram_addr);
    end
    step(); step();
    aux_req = 0; rd_sel = 0; rd_bank = 0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_video_during_cpu();
    test_starvation();
    test_simultaneous();
    test_reset_mid_access();
    test_ramdisk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
